fs_ratio_scheduler: RTL
=======================

Name: fs_ratio_scheduler

Overview:
- Monitors the incoming I2S-style clocks (bck, lrck) in the mclk domain and measures bck edges per lrck frame.
- Classifies the source as 32fs, 64fs or 128fs.
- Drives the path-select mux that chooses which format converter feeds the 16-bit left-justified 32fs DAC interface.
- Holds mute asserted while the source is absent, unstable or switching, so the DAC never sees a half-converted stream.

Parameters:
- LOCK_FRAMES, 4: consecutive frames with identical classification required before a path is applied.
- SETTLE_FRAMES, 8: frames the newly selected converter runs muted before unmute.
- TOL, 2: allowed deviation (in bck edges) from the nominal 32/64/128 count.
- TIMEOUT_CYC, 65535: mclk cycles without an lrck rising edge before loss of source is declared.

Ports:
- mclk, input, 1: system clock. Must be at least 4x the maximum bck frequency (24.576 MHz minimum for 128fs at 48 kHz).
- rst_n, input, 1: asynchronous, active-low reset.
- bck, input, 1: source bit clock, asynchronous to mclk.
- lrck, input, 1: source frame clock, asynchronous to mclk.
- mode_sel, output, 2: converter select. 00 = none, 01 = 32fs, 10 = 64fs, 11 = 128fs.
- mute, output, 1: DAC mute, 1 = muted.
- locked, output, 1: 1 only in LOCKED state.
- bck_per_frame, output, 8: last completed frame count, saturating at 255.

Behaviour:
- Clocking and reset:
  - Single clock mclk; reset is asynchronous and active-low.
  - Reset values: mode_sel = 00, mute = 1, locked = 0, bck_per_frame = 0. All counters are 0, the FSM is in UNLOCKED and the armed flag is cleared.
- Input synchronisation:
  - bck and lrck each pass through a 2-flop synchroniser, then a registered rising-edge detect.
  - An input edge is therefore seen 3 mclk after it occurs. Outputs respond on the following mclk, for 4 mclk total latency.
- Frame measurement:
  - A frame runs from one lrck rising edge to the next.
  - The bck edge counter increments on each detected bck rising edge and saturates at 255.
  - On an lrck rising edge, bck_per_frame is loaded with the count, a frame_done pulse is generated, and the counter restarts.
  - A bck edge detected in the same mclk as an lrck edge counts into the new frame: the counter restarts at 1.
  - The first lrck edge after reset or after a timeout only sets the armed flag. No frame_done is produced, because that frame was partial.
- Classification (combinational on the completed count):
  - |n−32| ≤ TOL gives 01.
  - |n−64| ≤ TOL gives 10.
  - |n−128| ≤ TOL gives 11.
  - Anything else is INVALID.
- Timeout:
  - The mclk-cycle counter clears on every lrck rising edge.
  - When it reaches TIMEOUT_CYC: FSM goes to UNLOCKED, mode_sel = 00, mute = 1, locked = 0, and the armed flag is cleared.
  - Timeout has priority over frame_done and applies in every state.
- FSM, with all transitions evaluated on frame_done unless noted:
  - UNLOCKED: mute = 1, mode_sel = 00. A valid class loads cand = class and match = 1, then goes to VERIFY. INVALID stays in UNLOCKED.
  - VERIFY: mute = 1 and mode_sel holds its previous value.
    - class == cand: match increments. When match reaches LOCK_FRAMES, mode_sel takes cand, the settle count goes to 0, and the FSM goes to SETTLE.
    - Different valid class: cand takes the new class, match = 1, stay in VERIFY.
    - INVALID: go to UNLOCKED, mode_sel = 00.
  - SETTLE: mute = 1.
    - class == mode_sel: settle count increments. When it reaches SETTLE_FRAMES, go to LOCKED, with mute = 0 and locked = 1 on the same mclk.
    - Any mismatch: go to UNLOCKED, mode_sel = 00.
  - LOCKED: mute = 0.
    - class == mode_sel: stay in LOCKED.
    - Mismatch: mute = 1 and locked = 0 on the next mclk.
      - Valid new class: go to VERIFY with cand = class, match = 1, and mode_sel unchanged.
      - INVALID: go to UNLOCKED.
- Output constraints:
  - mode_sel changes only at the VERIFY→SETTLE transition or on entry to UNLOCKED.
  - mute is always 1 whenever mode_sel changes.
- Reset mid-operation: all state and outputs return to their reset values immediately, asynchronously.

Test Plan:
- Clean 64fs stream (64 bck per lrck) from reset, defaults:
  - Frame 1 ends: VERIFY.
  - Frame 4 ends: mode_sel = 10, SETTLE.
  - Frame 12 ends: locked = 1, mute = 0, bck_per_frame = 64.
- Locked at 64fs, source switches to 128fs:
  - mute = 1 within 4 mclk of the first 128-bck frame end; mode_sel stays 10 during VERIFY.
  - 4 frames later mode_sel = 11.
  - 8 further frames later mute = 0.
- Jitter with 65 and 63 bck frames interleaved at 64fs: stays LOCKED with mute = 0.
- One 48-bck frame while locked: next mclk after frame end gives mute = 1, mode_sel = 00, locked = 0.
- lrck stops while locked: exactly TIMEOUT_CYC mclk after the last edge, mute = 1, mode_sel = 00, locked = 0.
  - When lrck restarts, the first edge only arms; the first classified frame is the second full frame.
- rst_n pulsed low mid-SETTLE at 32fs: outputs go immediately to mode_sel = 00, mute = 1, locked = 0.
  - After release, the full relock sequence completes in 12 frames.

Source files
------------

// File: rtl/fs_ratio_scheduler.sv
// fs_ratio_scheduler: measures bck rising edges per lrck frame in the mclk domain,
// classifies the source as 32fs/64fs/128fs, and drives the converter select and DAC mute.
// Ports:
//   mclk          - system clock (>= 4x max bck frequency)
//   rst_n         - asynchronous active-low reset
//   bck, lrck     - source bit/frame clocks, asynchronous to mclk
//   mode_sel[1:0] - converter select: 00 none, 01 32fs, 10 64fs, 11 128fs
//   mute          - DAC mute, 1 = muted
//   locked        - high only while the FSM is in the locked state
//   bck_per_frame - last completed frame count, saturating at 255
module fs_ratio_scheduler #(
  parameter int unsigned LOCK_FRAMES   = 4,
  parameter int unsigned SETTLE_FRAMES = 8,
  parameter int unsigned TOL           = 2,
  parameter int unsigned TIMEOUT_CYC   = 65535
) (
  input  logic       mclk,
  input  logic       rst_n,
  input  logic       bck,
  input  logic       lrck,
  output logic [1:0] mode_sel,
  output logic       mute,
  output logic       locked,
  output logic [7:0] bck_per_frame
);

  localparam int unsigned MW = $clog2(LOCK_FRAMES + 1);
  localparam int unsigned SW = $clog2(SETTLE_FRAMES + 1);
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StUnlocked, StVerify, StSettle, StLocked} state_e;

  // Class code 00 doubles as INVALID since every valid class is non-zero.
  function automatic logic [1:0] classify(logic [7:0] n);
    int unsigned v;
    v = 32'(n);
    if (v + TOL >= 32'd32 && v <= 32'd32 + TOL) return 2'b01;
    if (v + TOL >= 32'd64 && v <= 32'd64 + TOL) return 2'b10;
    if (v + TOL >= 32'd128 && v <= 32'd128 + TOL) return 2'b11;
    return 2'b00;
  endfunction

  logic          bck_s1_q, bck_s2_q, bck_d3_q, bck_rise_q, bck_rise_d;
  logic          lr_s1_q, lr_s2_q, lr_d3_q, lr_rise_q, lr_rise_d;
  state_e        state_q, state_d;
  logic [1:0]    cand_q, cand_d, mode_q, mode_d, cls;
  logic [MW-1:0] match_q, match_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [7:0]    cnt_q, cnt_d, bpf_q, bpf_d;
  logic          mute_q, mute_d, locked_q, locked_d, armed_q, armed_d;
  logic          frame_done, timeout;

  assign bck_rise_d = bck_s2_q & ~bck_d3_q;
  assign lr_rise_d  = lr_s2_q & ~lr_d3_q;
  assign cls        = classify(cnt_q);
  // The first lrck edge after reset/timeout only arms: that frame was partial.
  assign frame_done = lr_rise_q & armed_q;
  assign timeout    = ~lr_rise_q & (32'(cyc_q) == TIMEOUT_CYC - 32'd1);

  // Frame counter, timeout counter and arming.
  always_comb begin
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    armed_d = armed_q;
    bpf_d   = bpf_q;
    if (lr_rise_q) begin
      // A bck edge coincident with lrck belongs to the new frame.
      cnt_d   = bck_rise_q ? 8'd1 : 8'd0;
      cyc_d   = '0;
      armed_d = 1'b1;
      if (frame_done) bpf_d = cnt_q;
    end else begin
      if (bck_rise_q && cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
      if (cyc_q != CW'(TIMEOUT_CYC)) cyc_d = cyc_q + CW'(1);
    end
    if (timeout) begin
      armed_d = 1'b0;
      cnt_d   = '0;
    end
  end

  // Lock/settle FSM; all transitions except timeout happen on frame_done.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    match_d  = match_q;
    settle_d = settle_q;
    mode_d   = mode_q;
    mute_d   = mute_q;
    locked_d = locked_q;
    if (timeout) begin
      state_d  = StUnlocked;
      mode_d   = 2'b00;
      mute_d   = 1'b1;
      locked_d = 1'b0;
    end else if (frame_done) begin
      unique case (state_q)
        StUnlocked: begin
          mute_d = 1'b1;
          mode_d = 2'b00;
          if (cls != 2'b00) begin
            cand_d  = cls;
            match_d = MW'(1);
            state_d = StVerify;
          end
        end
        StVerify: begin
          mute_d = 1'b1;
          if (cls == 2'b00) begin
            state_d = StUnlocked;
            mode_d  = 2'b00;
          end else if (cls == cand_q) begin
            match_d = match_q + MW'(1);
            if (32'(match_q) + 32'd1 == LOCK_FRAMES) begin
              mode_d   = cand_q;
              settle_d = '0;
              state_d  = StSettle;
            end
          end else begin
            cand_d  = cls;
            match_d = MW'(1);
          end
        end
        StSettle: begin
          mute_d = 1'b1;
          if (cls == mode_q) begin
            settle_d = settle_q + SW'(1);
            if (32'(settle_q) + 32'd1 == SETTLE_FRAMES) begin
              state_d  = StLocked;
              mute_d   = 1'b0;
              locked_d = 1'b1;
            end
          end else begin
            state_d = StUnlocked;
            mode_d  = 2'b00;
          end
        end
        StLocked: begin
          if (cls != mode_q) begin
            mute_d   = 1'b1;
            locked_d = 1'b0;
            if (cls != 2'b00) begin
              cand_d  = cls;
              match_d = MW'(1);
              state_d = StVerify;
            end else begin
              state_d = StUnlocked;
              mode_d  = 2'b00;
            end
          end
        end
        default: state_d = StUnlocked;
      endcase
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      bck_s1_q   <= 1'b0;
      bck_s2_q   <= 1'b0;
      bck_d3_q   <= 1'b0;
      bck_rise_q <= 1'b0;
      lr_s1_q    <= 1'b0;
      lr_s2_q    <= 1'b0;
      lr_d3_q    <= 1'b0;
      lr_rise_q  <= 1'b0;
      state_q    <= StUnlocked;
      cand_q     <= 2'b00;
      match_q    <= '0;
      settle_q   <= '0;
      cyc_q      <= '0;
      cnt_q      <= '0;
      bpf_q      <= '0;
      mode_q     <= 2'b00;
      mute_q     <= 1'b1;
      locked_q   <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      bck_s1_q   <= bck;
      bck_s2_q   <= bck_s1_q;
      bck_d3_q   <= bck_s2_q;
      bck_rise_q <= bck_rise_d;
      lr_s1_q    <= lrck;
      lr_s2_q    <= lr_s1_q;
      lr_d3_q    <= lr_s2_q;
      lr_rise_q  <= lr_rise_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      match_q    <= match_d;
      settle_q   <= settle_d;
      cyc_q      <= cyc_d;
      cnt_q      <= cnt_d;
      bpf_q      <= bpf_d;
      mode_q     <= mode_d;
      mute_q     <= mute_d;
      locked_q   <= locked_d;
      armed_q    <= armed_d;
    end
  end

  assign mode_sel      = mode_q;
  assign mute          = mute_q;
  assign locked        = locked_q;
  assign bck_per_frame = bpf_q;

endmodule
